int_countdn_seq: RTL and testbench
==================================

INT_COUNTDN_SEQ -- requirements
Module: int_countdn_seq

Interface
REQ-001 SHALL provide parameter: CNT_W, 12, width of each countdown channel.
REQ-002 SHALL use one clock, SIM_CLK; reset SIM_RST is synchronous and active-high.
REQ-003 SHALL provide ports:
  SIM_CLK  in  1  system clock
  SIM_RST  in  1  synchronous active-high reset
  PH_EN    in  1  phase advance enable
  LD_REQ   in  1  load request, held until LD_ACK
  LD_SEL   in  1  load target: 0=C2, 1=C3
  LD_DATA  in  CNT_W  load value
  LD_ACK   out 1  one-cycle load acknowledge
  CH_EN    in  2  countdown enable, bit0=C2, bit1=C3
  INT_ACK  in  2  pending-interrupt clear, bit0=C2, bit1=C3
  W4       out 1  phase strobe
  X4       out 1  phase strobe
  Y5       out 1  phase strobe
  Z5       out 1  phase strobe
  V1       out 1  phase strobe
  C2_CNT   out CNT_W  channel C2 count
  C3_CNT   out CNT_W  channel C3 count
  TCZ      out 2  count==0 flags, bit0=C2, bit1=C3
  INT_PEND out 2  latched terminal-count interrupts
  IRQ      out 1  OR of INT_PEND

Function
REQ-004 SHALL implement a phase FSM with states W4->X4->Y5->Z5->V1->W4, one transition per edge with PH_EN=1, holding state when PH_EN=0.
REQ-005 SHALL drive exactly one phase strobe high at all times, decoded from registered state.
REQ-006 SHALL accept LD_REQ only at an edge where state=W4 and PH_EN=1, writing LD_DATA to the channel selected by LD_SEL at that edge.
REQ-007 SHALL assert LD_ACK for exactly the one cycle after the accepting edge; LD_REQ seen in any other phase waits, unacknowledged.
REQ-008 SHALL permit loads regardless of CH_EN.
REQ-009 SHALL decrement by 1 each channel with CH_EN bit=1 and count!=0 at an edge where state=V1 and PH_EN=1.
REQ-010 SHALL hold a count at 0 (no wrap) and freeze any channel with CH_EN bit=0.
REQ-011 SHALL set INT_PEND bit at the edge a decrement takes its count from 1 to 0; a load of 0 SHALL NOT set INT_PEND.
REQ-012 SHALL clear INT_PEND bit at the edge its INT_ACK bit is 1, regardless of PH_EN; set and clear on the same edge SHALL leave the bit set.
REQ-013 SHALL drive TCZ[i]=(count==0) and IRQ=|INT_PEND combinationally from registers.
REQ-014 SHALL freeze phase, counts and loads while PH_EN=0; INT_ACK clears still take effect.

Reset
REQ-015 SHALL, at an edge with SIM_RST=1, set state=W4 (W4=1, others 0), C2_CNT=C3_CNT=0, LD_ACK=0, INT_PEND=0, overriding all other inputs, including mid-countdown or mid-handshake.
REQ-016 SHALL report TCZ=2'b11 and IRQ=0 after reset.

Verification
REQ-017 Reset, PH_EN=1 for 11 cycles -> strobes W4,X4,Y5,Z5,V1 repeating with period 5, always one-hot.
REQ-018 Load C2=3 (LD_SEL=0), CH_EN=01 -> LD_ACK one cycle after W4 edge; C2_CNT 3,2,1,0 at successive V1 edges; INT_PEND=01, IRQ=1 at the 1->0 edge; C2_CNT remains 0.
REQ-019 LD_REQ raised in Y5 with LD_SEL=1, LD_DATA=0x005 -> not accepted until next W4 edge; LD_ACK exactly one cycle; C3_CNT=5, INT_PEND unchanged.
REQ-020 INT_ACK[0]=1 on the same edge as C2 1->0 -> INT_PEND[0]=1; INT_ACK[0]=1 next cycle -> INT_PEND[0]=0, IRQ=0.
REQ-021 PH_EN=0 for 4 cycles in V1 with C2=2 enabled -> strobe holds V1, C2_CNT stays 2; decrement to 1 on first edge after PH_EN returns to 1.
REQ-022 SIM_RST=1 mid-countdown with C3=7, INT_PEND=10 -> next edge: C3_CNT=0, INT_PEND=0, W4=1, LD_ACK=0.

Source files
------------

// File: rtl/int_countdn_seq.sv
// int_countdn_seq: five-phase strobe sequencer with two loadable down-counting
// channels (C2, C3). Loads are accepted in phase W4 and counts decrement in
// phase V1. A channel that counts down from 1 to 0 latches a pending interrupt,
// which stays set until it is acknowledged.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   W4    | load window: a pending LD_REQ is accepted on a PH_EN edge
//   X4    | idle phase
//   Y5    | idle phase
//   Z5    | idle phase
//   V1    | count window: enabled non-zero channels decrement on PH_EN
module int_countdn_seq #(
  parameter int CNT_W = 12
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             PH_EN,
  input  logic             LD_REQ,
  input  logic             LD_SEL,
  input  logic [CNT_W-1:0] LD_DATA,
  output logic             LD_ACK,
  input  logic [1:0]       CH_EN,
  input  logic [1:0]       INT_ACK,
  output logic             W4,
  output logic             X4,
  output logic             Y5,
  output logic             Z5,
  output logic             V1,
  output logic [CNT_W-1:0] C2_CNT,
  output logic [CNT_W-1:0] C3_CNT,
  output logic [1:0]       TCZ,
  output logic [1:0]       INT_PEND,
  output logic             IRQ
);

  typedef enum logic [2:0] {
    ST_W4 = 3'd0,
    ST_X4 = 3'd1,
    ST_Y5 = 3'd2,
    ST_Z5 = 3'd3,
    ST_V1 = 3'd4
  } phase_t;

  phase_t                  state_q;
  phase_t                  state_d;
  logic [1:0][CNT_W-1:0]   cnt_q;
  logic [1:0]              pend_q;
  logic                    ack_q;
  logic                    ld_fire;
  logic                    dec_fire;
  logic [1:0]              ld_hit;
  logic [1:0]              dec_hit;
  logic [1:0]              tc_hit;

  // Phase register; only advances on PH_EN edges.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) state_q <= ST_W4;
    else         state_q <= state_d;
  end

  // Next phase and one-hot strobe decode from the registered phase.
  always_comb begin
    state_d = state_q;
    W4 = 1'b0;
    X4 = 1'b0;
    Y5 = 1'b0;
    Z5 = 1'b0;
    V1 = 1'b0;
    case (state_q)
      ST_W4: begin W4 = 1'b1; if (PH_EN) state_d = ST_X4; end
      ST_X4: begin X4 = 1'b1; if (PH_EN) state_d = ST_Y5; end
      ST_Y5: begin Y5 = 1'b1; if (PH_EN) state_d = ST_Z5; end
      ST_Z5: begin Z5 = 1'b1; if (PH_EN) state_d = ST_V1; end
      ST_V1: begin V1 = 1'b1; if (PH_EN) state_d = ST_W4; end
      default: state_d = ST_W4;
    endcase
  end

  // Per-channel load, decrement and terminal-count qualifiers.
  always_comb begin
    ld_fire  = PH_EN && (state_q == ST_W4) && LD_REQ;
    dec_fire = PH_EN && (state_q == ST_V1);
    ld_hit   = {ld_fire & LD_SEL, ld_fire & ~LD_SEL};
    dec_hit  = 2'b00;
    tc_hit   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      dec_hit[i] = dec_fire && CH_EN[i] && (cnt_q[i] != '0);
      tc_hit[i]  = dec_hit[i] && (cnt_q[i] == CNT_W'(1));
    end
  end

  // Channel counters: loads land in W4, decrements in V1, so they never collide.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ld_hit[i])       cnt_q[i] <= LD_DATA;
        else if (dec_hit[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Pending interrupts: a new terminal count wins over a same-edge acknowledge.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) pend_q <= 2'b00;
    else         pend_q <= (pend_q & ~INT_ACK) | tc_hit;
  end

  // Load acknowledge pulses for the single cycle after the accepting edge.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) ack_q <= 1'b0;
    else         ack_q <= ld_fire;
  end

  assign LD_ACK   = ack_q;
  assign C2_CNT   = cnt_q[0];
  assign C3_CNT   = cnt_q[1];
  assign TCZ      = {cnt_q[1] == '0, cnt_q[0] == '0};
  assign INT_PEND = pend_q;
  assign IRQ      = |pend_q;

endmodule

// File: tb/tb_int_countdn_seq.sv
// Testbench for int_countdn_seq: a fixed vector table for the basic load and
// countdown flow, hand-written sequences for the multi-cycle corner cases, and
// a randomized run checked against a phase-index/integer reference model.
module tb_int_countdn_seq;

  localparam int CNT_W = 12;
  localparam logic [4:0] S_W4 = 5'b00001;
  localparam logic [4:0] S_X4 = 5'b00010;
  localparam logic [4:0] S_Y5 = 5'b00100;
  localparam logic [4:0] S_Z5 = 5'b01000;
  localparam logic [4:0] S_V1 = 5'b10000;

  logic             clk = 1'b0;
  logic             rst;
  logic             ph_en;
  logic             ld_req;
  logic             ld_sel;
  logic [CNT_W-1:0] ld_data;
  logic [1:0]       ch_en;
  logic [1:0]       int_ack;
  logic             ld_ack;
  logic             w4, x4, y5, z5, v1;
  logic [CNT_W-1:0] c2_cnt, c3_cnt;
  logic [1:0]       tcz, int_pend;
  logic             irq;

  int errors = 0;
  int checks = 0;

  // Reference model: phase as an index 0..4 (W4,X4,Y5,Z5,V1), counts as ints.
  int       m_ph;
  int       m_cnt[2];
  bit       m_ack;
  bit [1:0] m_pend;

  int_countdn_seq #(.CNT_W(CNT_W)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .PH_EN(ph_en), .LD_REQ(ld_req),
    .LD_SEL(ld_sel), .LD_DATA(ld_data), .LD_ACK(ld_ack), .CH_EN(ch_en),
    .INT_ACK(int_ack), .W4(w4), .X4(x4), .Y5(y5), .Z5(z5), .V1(v1),
    .C2_CNT(c2_cnt), .C3_CNT(c3_cnt), .TCZ(tcz), .INT_PEND(int_pend), .IRQ(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] strobes();
    return {v1, z5, y5, x4, w4};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_update();
    bit [1:0] np;
    if (rst) begin
      m_ph = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_ack = 0; m_pend = 2'b00;
      return;
    end
    np = m_pend & ~int_ack;
    m_ack = 0;
    if (ph_en) begin
      if (m_ph == 0 && ld_req) begin
        m_cnt[ld_sel] = int'(ld_data);
        m_ack = 1;
      end
      if (m_ph == 4) begin
        for (int i = 0; i < 2; i++) begin
          if (ch_en[i] && m_cnt[i] > 0) begin
            m_cnt[i] = m_cnt[i] - 1;
            if (m_cnt[i] == 0) np[i] = 1'b1;
          end
        end
      end
      m_ph = (m_ph + 1) % 5;
    end
    m_pend = np;
  endfunction

  // One clock edge: advance the model, then compare all outputs 1ns later.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("m_strobe", 32'(strobes()), 32'(5'b00001 << m_ph));
    chk("m_c2", 32'(c2_cnt), 32'(m_cnt[0]));
    chk("m_c3", 32'(c3_cnt), 32'(m_cnt[1]));
    chk("m_ack", 32'(ld_ack), 32'(m_ack));
    chk("m_pend", 32'(int_pend), 32'(m_pend));
    chk("m_tcz", 32'(tcz), 32'({m_cnt[1] == 0, m_cnt[0] == 0}));
    chk("m_irq", 32'(irq), 32'(m_pend != 2'b00));
  endtask

  task automatic idle_inputs();
    rst = 0; ph_en = 1; ld_req = 0; ld_sel = 0; ld_data = '0; int_ack = 2'b00;
  endtask

  // Advance with PH_EN=1 until the strobe for phase p is up (bounded).
  task automatic goto_phase(input int p);
    ph_en = 1;
    for (int k = 0; k < 6 && m_ph != p; k++) tick();
    chk("goto_phase", 32'(strobes()), 32'(5'b00001 << p));
  endtask

  // Load a channel at the next W4 edge, dropping the request after the ack.
  task automatic load(input logic sel, input int val);
    goto_phase(0);
    ld_req = 1; ld_sel = sel; ld_data = CNT_W'(val);
    tick();
    chk("load_ack", 32'(ld_ack), 32'd1);
    ld_req = 0;
  endtask

  typedef struct {
    logic             rst, ph_en, ld_req, ld_sel;
    logic [CNT_W-1:0] ld_data;
    logic [1:0]       ch_en, int_ack;
    logic [4:0]       e_strb;
    logic [CNT_W-1:0] e_c2;
    logic             e_ack;
    logic [1:0]       e_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic pe, logic lr, logic ls, int ld,
                              logic [1:0] ce, logic [1:0] ia, logic [4:0] s,
                              int c2, logic a, logic [1:0] p);
    vec_t v;
    v.rst = r; v.ph_en = pe; v.ld_req = lr; v.ld_sel = ls; v.ld_data = CNT_W'(ld);
    v.ch_en = ce; v.int_ack = ia; v.e_strb = s; v.e_c2 = CNT_W'(c2);
    v.e_ack = a; v.e_pend = p;
    return v;
  endfunction

  initial begin
    // Reset, then load C2=3 and count it down to 0 across V1 edges.
    tbl.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b00, S_W4, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1, 0, 3, 2'b01, 2'b00, S_X4, 3, 1, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_Y5, 3, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_Z5, 3, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_V1, 3, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_W4, 2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_X4, 2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_Y5, 2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_Z5, 2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_V1, 2, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_W4, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_X4, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_Y5, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_Z5, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_V1, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_W4, 0, 0, 2'b01));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_X4, 0, 0, 2'b01));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_Y5, 0, 0, 2'b01));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_Z5, 0, 0, 2'b01));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_V1, 0, 0, 2'b01));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 2'b00, S_W4, 0, 0, 2'b01));

    idle_inputs();
    rst = 1; ch_en = 2'b00;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; ph_en = tbl[i].ph_en; ld_req = tbl[i].ld_req;
      ld_sel = tbl[i].ld_sel; ld_data = tbl[i].ld_data; ch_en = tbl[i].ch_en;
      int_ack = tbl[i].int_ack;
      tick();
      chk($sformatf("tbl%0d_strobe", i), 32'(strobes()), 32'(tbl[i].e_strb));
      chk($sformatf("tbl%0d_c2", i), 32'(c2_cnt), 32'(tbl[i].e_c2));
      chk($sformatf("tbl%0d_ack", i), 32'(ld_ack), 32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_pend", i), 32'(int_pend), 32'(tbl[i].e_pend));
      if (i == 0) begin
        chk("rst_tcz", 32'(tcz), 32'd3);
        chk("rst_irq", 32'(irq), 32'd0);
      end
    end
    chk("tc_irq", 32'(irq), 32'd1);

    // Request raised in Y5 waits for the next W4 edge, then acks for one cycle.
    idle_inputs();
    goto_phase(2);
    ld_req = 1; ld_sel = 1; ld_data = CNT_W'(5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("early_no_ack", 32'(ld_ack), 32'd0);
      chk("early_c3", 32'(c3_cnt), 32'd0);
    end
    tick();
    chk("late_ack", 32'(ld_ack), 32'd1);
    chk("late_c3", 32'(c3_cnt), 32'd5);
    chk("late_pend", 32'(int_pend), 32'd1);
    ld_req = 0;
    tick();
    chk("ack_one_cycle", 32'(ld_ack), 32'd0);

    // Same-edge set and ack leaves the bit set; ack on the next edge clears it.
    ph_en = 0; int_ack = 2'b01;
    tick();
    chk("ack_clear_held", 32'(int_pend), 32'd0);
    int_ack = 2'b00;
    load(0, 1);
    goto_phase(4);
    int_ack = 2'b01;
    tick();
    chk("set_wins_c2", 32'(c2_cnt), 32'd0);
    chk("set_wins_pend", 32'(int_pend), 32'd1);
    ph_en = 0;
    tick();
    chk("ack_next_pend", 32'(int_pend), 32'd0);
    chk("ack_next_irq", 32'(irq), 32'd0);
    int_ack = 2'b00; ph_en = 1;

    // PH_EN low in V1 freezes phase and counts.
    load(0, 2);
    goto_phase(4);
    ph_en = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hold_strobe", 32'(strobes()), 32'(S_V1));
      chk("hold_c2", 32'(c2_cnt), 32'd2);
    end
    ph_en = 1;
    tick();
    chk("resume_c2", 32'(c2_cnt), 32'd1);
    chk("resume_strobe", 32'(strobes()), 32'(S_W4));

    // Reset mid-countdown with C3 pending and a load request in flight.
    ch_en = 2'b11;
    load(1, 1);
    goto_phase(0);
    chk("pre_rst_c3pend", 32'(int_pend[1]), 32'd1);
    int_ack = 2'b01;
    tick();
    int_ack = 2'b00;
    load(1, 7);
    goto_phase(0);
    chk("pre_rst_c3", 32'(c3_cnt), 32'd6);
    chk("pre_rst_pend", 32'(int_pend), 32'd2);
    rst = 1; ld_req = 1; ld_sel = 1; ld_data = CNT_W'(9);
    tick();
    chk("rst_c3", 32'(c3_cnt), 32'd0);
    chk("rst_pend", 32'(int_pend), 32'd0);
    chk("rst_w4", 32'(strobes()), 32'(S_W4));
    chk("rst_ack", 32'(ld_ack), 32'd0);
    idle_inputs();

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      ph_en   = ($urandom_range(0, 9) < 8);
      ld_req  = ($urandom_range(0, 3) == 0);
      ld_sel  = 1'($urandom_range(0, 1));
      ld_data = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 3));
      ch_en   = 2'($urandom_range(0, 3));
      int_ack = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
